// File: rtl/clk_en_synth_if.sv
// Sync strobe, reconfiguration handshake and per-channel enable outputs of clk_en_synth.
interface clk_en_synth_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] locked;

    modport master (
        output sync,
        output cfg_valid,
        output cfg_ch,
        output cfg_inc,
        input  cfg_ready,
        input  clk_en,
        input  outclk,
        input  locked
    );

    modport slave (
        input  sync,
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_inc,
        output cfg_ready,
        output clk_en,
        output outclk,
        output locked
    );
endinterface

// File: rtl/clk_en_synth.sv
// Multi-channel DDS clock-enable generator with glitch-free runtime rate change.
// Latency: clk_en is registered one cycle after the overflowing add; new rates go live at the next wrap.
// Backpressure: cfg_ready is low while the addressed channel still holds an unapplied increment.
module clk_en_synth #(
    parameter int              NUM_CH      = 2,
    parameter int              ACC_W       = 32,
    parameter longint unsigned DEFAULT_INC = 64'd2162571352,
    parameter int              LOCK_CNT    = 16
) (
    input  logic          refclk,
    input  logic          rst,
    clk_en_synth_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PAD_W = 1 << CH_W;
    localparam int LCW   = $clog2(LOCK_CNT + 1);

    localparam logic [ACC_W-1:0] RST_INC  = ACC_W'(DEFAULT_INC);
    localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CNT);

    logic [NUM_CH-1:0] pending;
    logic [PAD_W-1:0]  pend_pad;
    logic              cfg_fire;

    // Channel numbers beyond NUM_CH index the zero padding, so they are accepted and dropped.
    assign pend_pad      = PAD_W'(pending);
    assign bus.cfg_ready = rst & ~pend_pad[bus.cfg_ch];
    assign cfg_fire      = bus.cfg_valid & bus.cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] pend_inc;
        logic             pend;
        logic             en_q;
        logic             clk_q;
        logic             lock_q;
        logic [LCW-1:0]   lock_cnt;
        logic [ACC_W:0]   sum;
        logic             carry;
        logic             running;
        logic             take;
        logic             apply;

        assign sum     = {1'b0, acc} + {1'b0, inc};
        assign carry   = sum[ACC_W];
        assign running = |inc;
        assign take    = cfg_fire && (bus.cfg_ch == CH_W'(i));
        // A parked increment goes live on a wrap, on sync, or at once if the channel is off.
        assign apply   = pend && (bus.sync || carry || !running);

        always_ff @(posedge refclk) begin
            if (!rst) begin
                acc      <= '0;
                inc      <= RST_INC;
                pend_inc <= '0;
                pend     <= 1'b0;
                en_q     <= 1'b0;
                clk_q    <= 1'b0;
                lock_cnt <= '0;
                lock_q   <= 1'b0;
            end else begin
                if (take) begin
                    pend_inc <= bus.cfg_inc;
                    pend     <= 1'b1;
                end else if (apply) begin
                    inc  <= pend_inc;
                    pend <= 1'b0;
                end

                if (bus.sync || !running) begin
                    if (bus.sync) begin
                        acc <= '0;
                    end
                    en_q     <= 1'b0;
                    clk_q    <= 1'b0;
                    lock_cnt <= '0;
                    lock_q   <= 1'b0;
                end else begin
                    // Accumulator keeps its phase across a rate change.
                    acc   <= sum[ACC_W-1:0];
                    en_q  <= carry;
                    clk_q <= clk_q ^ carry;
                    if (apply) begin
                        lock_cnt <= '0;
                        lock_q   <= 1'b0;
                    end else begin
                        if (carry && (lock_cnt != LOCK_MAX)) begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                        lock_q <= (lock_cnt == LOCK_MAX);
                    end
                end
            end
        end

        assign pending[i]    = pend;
        assign bus.clk_en[i] = en_q;
        assign bus.outclk[i] = clk_q;
        assign bus.locked[i] = lock_q;
    end
endmodule

// File: tb/tb_clk_en_synth.sv
// Directed and randomized checks of clk_en_synth against a cycle-level arithmetic model.
module tb_clk_en_synth;
    localparam int     NUM_CH   = 2;
    localparam int     ACC_W    = 32;
    localparam int     CH_W     = 1;
    localparam int     LOCK_CNT = 16;
    localparam longint DEF_INC  = 64'd2162571352;
    localparam longint TWO32    = 64'h1_0000_0000;

    logic refclk = 1'b0;
    logic rst    = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    clk_en_synth_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

    clk_en_synth #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .DEFAULT_INC(64'd2162571352),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    // Reference model state: values visible during cycle 'cyc'
    longint m_acc     [NUM_CH];
    longint m_inc     [NUM_CH];
    longint m_pinc    [NUM_CH];
    bit     m_pend    [NUM_CH];
    bit     m_en      [NUM_CH];
    bit     m_oc      [NUM_CH];
    int     m_cnt     [NUM_CH];
    longint m_lock_at [NUM_CH];
    longint cyc     = 0;
    bit     m_valid = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit model_ready();
        int ch;
        ch = int'(bus.cfg_ch);
        if (!rst) return 1'b0;
        if (ch < NUM_CH && m_pend[ch]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge refclk) begin : model
        bit     xfer;
        int     sel;
        longint s;
        bit     wrap;
        bit     app;
        cyc++;
        if (!rst) begin
            m_valid = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_acc[i] = 0; m_inc[i] = DEF_INC; m_pinc[i] = 0; m_pend[i] = 1'b0;
                m_en[i] = 1'b0; m_oc[i] = 1'b0; m_cnt[i] = 0; m_lock_at[i] = -1;
            end
        end else if (m_valid) begin
            xfer = bus.cfg_valid && model_ready();
            sel  = int'(bus.cfg_ch);
            for (int i = 0; i < NUM_CH; i++) begin
                s    = m_acc[i] + m_inc[i];
                wrap = (s >= TWO32);
                app  = m_pend[i] && (bus.sync || wrap || m_inc[i] == 0);
                if (bus.sync) begin
                    m_acc[i] = 0; m_en[i] = 1'b0; m_oc[i] = 1'b0; m_cnt[i] = 0; m_lock_at[i] = -1;
                end else if (m_inc[i] == 0) begin
                    m_en[i] = 1'b0; m_oc[i] = 1'b0; m_cnt[i] = 0; m_lock_at[i] = -1;
                end else begin
                    m_acc[i] = s % TWO32;
                    m_en[i]  = wrap;
                    if (wrap) m_oc[i] = !m_oc[i];
                    if (app) begin
                        m_cnt[i] = 0; m_lock_at[i] = -1;
                    end else if (wrap) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == LOCK_CNT) m_lock_at[i] = cyc;
                    end
                end
                if (app) begin
                    m_inc[i] = m_pinc[i]; m_pend[i] = 1'b0;
                end
                if (xfer && sel == i) begin
                    m_pinc[i] = longint'(bus.cfg_inc); m_pend[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge refclk) begin : compare
        if (m_valid) begin
            chk("cfg_ready", bus.cfg_ready, model_ready());
            for (int i = 0; i < NUM_CH; i++) begin
                chk($sformatf("clk_en%0d", i), bus.clk_en[i], m_en[i]);
                chk($sformatf("outclk%0d", i), bus.outclk[i], m_oc[i]);
                chk($sformatf("locked%0d", i), bus.locked[i], (m_lock_at[i] >= 0 && cyc > m_lock_at[i]));
            end
        end
    end

    task automatic do_cfg(input int ch, input longint v);
        bit rdy;
        int n;
        rdy = 1'b0;
        n   = 0;
        @(posedge refclk); #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_inc   = ACC_W'(v);
        while (!rdy && n < 200) begin
            @(negedge refclk);
            rdy = bus.cfg_ready;
            @(posedge refclk); #1;
            n++;
        end
        bus.cfg_valid = 1'b0;
        tests++;
        if (!rdy) begin
            fails++;
            $display("FAIL cfg_accept ch%0d: not accepted within %0d cycles, required acceptance", ch, n);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!bus.cfg_ready && n < 200);
        tests++;
        if (!bus.cfg_ready) begin
            fails++;
            $display("FAIL %s: cfg_ready still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic count_pulses(input int ch, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge refclk);
            cnt += int'(bus.clk_en[ch]);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: run did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cnt;
        int first0;
        int first1;
        int n;
        bus.sync      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_inc   = '0;

        // Reset and default rate
        repeat (2) @(posedge refclk);
        #1 rst = 1'b1;
        @(negedge refclk);
        chk("rst_clk_en", bus.clk_en, 0);
        chk("rst_outclk", bus.outclk, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        count_pulses(0, 10000, cnt);
        tests++;
        if (cnt < 5034 || cnt > 5036) begin
            fails++;
            $display("FAIL default_rate: got %0d pulses, required 5035 +/-1", cnt);
        end
        chk("default_locked0", bus.locked[0], 1);
        chk("default_outclk0", bus.outclk[0], cnt % 2);

        // ch1 to half rate
        do_cfg(1, 64'h8000_0000);
        @(negedge refclk);
        chk("half_pending_ready", bus.cfg_ready, 0);
        wait_ready("half_apply");
        chk("half_unlock1", bus.locked[1], 0);
        count_pulses(1, 40, cnt);
        chk("half_pulses40", cnt, 20);
        chk("half_relock1", bus.locked[1], 1);
        chk("half_ch0_locked", bus.locked[0], 1);

        // Back-to-back cfg while pending, ending with channel off
        do_cfg(1, 64'h4000_0000);
        @(negedge refclk);
        chk("second_ready_low", bus.cfg_ready, 0);
        do_cfg(1, 64'h2000_0000);
        do_cfg(1, 0);
        wait_ready("off_apply");
        count_pulses(1, 20, cnt);
        chk("off_pulses", cnt, 0);
        chk("off_locked1", bus.locked[1], 0);
        chk("off_outclk1", bus.outclk[1], 0);

        // Off channel takes the new rate one cycle after acceptance
        do_cfg(1, 64'h4000_0000);
        @(negedge refclk);
        chk("from_off_pending", bus.cfg_ready, 0);
        @(negedge refclk);
        chk("from_off_applied", bus.cfg_ready, 1);
        count_pulses(1, 40, cnt);
        chk("quarter_pulses40", cnt, 10);

        // Phase alignment with sync
        do_cfg(0, 64'h4000_0000);
        wait_ready("sync_setup0");
        do_cfg(1, 64'h2000_0000);
        wait_ready("sync_setup1");
        repeat (30) @(negedge refclk);
        @(posedge refclk); #1 bus.sync = 1'b1;
        @(posedge refclk); #1 bus.sync = 1'b0;
        first0 = -1;
        first1 = -1;
        for (int j = 0; j < 12; j++) begin
            @(negedge refclk);
            if (j == 0) begin
                chk("sync_outclk", bus.outclk, 0);
                chk("sync_locked", bus.locked, 0);
                chk("sync_clk_en", bus.clk_en, 0);
            end
            if (first0 < 0 && bus.clk_en[0]) first0 = j;
            if (first1 < 0 && bus.clk_en[1]) first1 = j;
        end
        chk("sync_first_ch0", first0, 4);
        chk("sync_first_ch1", first1, 8);

        // Reset while a cfg is pending discards it
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!bus.clk_en[1] && n < 40);
        chk("rstpend_saw_pulse", bus.clk_en[1], 1);
        do_cfg(1, 64'h8000_0000);
        @(negedge refclk);
        chk("rstpend_pending", bus.cfg_ready, 0);
        @(posedge refclk); #1 rst = 1'b0;
        @(posedge refclk); #1 rst = 1'b1;
        @(negedge refclk);
        chk("rstpend_clk_en", bus.clk_en, 0);
        chk("rstpend_outclk", bus.outclk, 0);
        chk("rstpend_locked", bus.locked, 0);
        chk("rstpend_ready", bus.cfg_ready, 1);
        count_pulses(1, 1000, cnt);
        chk("rstpend_default_rate", cnt, 503);

        // Randomized traffic, including fast rates, sync collisions and stray resets
        for (int k = 0; k < 4000; k++) begin
            @(posedge refclk); #1;
            rst           = ($urandom_range(0, 799) != 0);
            bus.sync      = ($urandom_range(0, 99) == 0);
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            case ($urandom_range(0, 5))
                0:       bus.cfg_inc = '0;
                1:       bus.cfg_inc = 32'h8000_0000;
                2:       bus.cfg_inc = 32'h4000_0000;
                3:       bus.cfg_inc = 32'hFFFF_FFFF;
                default: bus.cfg_inc = ACC_W'($urandom());
            endcase
        end
        @(posedge refclk); #1;
        rst           = 1'b1;
        bus.sync      = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (20) @(negedge refclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clk_en_synth.md
Name: clk_en_synth

Overview:
- Parametrised, fully synchronous successor to the fixed single-output video PLL wrapper.
- Generates NUM_CH independent fractional-rate clock enables from `refclk` using per-channel DDS phase accumulators.
- Each channel also provides a 50%-duty toggle output and a per-channel locked flag.
- Frequencies are reprogrammable at runtime. Changes apply glitch-free at the next accumulator wrap, so pixel/timing logic downstream stays on one clock domain.

Parameters:
- NUM_CH, 2, number of independent enable channels (1..8).
- ACC_W, 32, phase accumulator and increment width.
- DEFAULT_INC, 2162571352, reset increment for every channel (≈25.175644 MHz enable rate at 50 MHz refclk).
- LOCK_CNT, 16, enables a channel must produce after reset/reconfig/sync before locked asserts (≥1).

Ports:
- refclk  in  1  single clock.
- rst  in  1  synchronous, active-low reset.
- sync  in  1  one-cycle strobe: phase-align all channels.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  reconfiguration accept.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_inc  in  ACC_W  new increment; 0 = channel off.
- clk_en  out  NUM_CH  one-refclk-cycle enable pulse per channel.
- outclk  out  NUM_CH  toggles on each clk_en (frequency = enable rate / 2).
- locked  out  NUM_CH  channel running and settled.

Behaviour:
- Reset (rst=0 at a refclk edge), all per channel:
  - acc=0, inc=DEFAULT_INC, pending=0.
  - clk_en=0, outclk=0, locked=0, lock counter=0.
  - cfg_ready=0 during reset, 1 on the first cycle after.
- Reset mid-operation discards any pending configuration.
- Accumulator, each cycle per channel:
  - {carry, acc} <= acc + inc, computed ACC_W+1 bits wide. The sum wraps modulo 2^ACC_W with no saturation.
  - clk_en[i] <= carry, a registered pulse one cycle after the overflowing add.
  - Mean enable rate = f_refclk × inc / 2^ACC_W.
  - clk_en never asserts on two consecutive cycles unless inc ≥ 2^(ACC_W-1).
- outclk[i] toggles in the same cycle that clk_en[i] is high.
- inc=0: accumulator held, clk_en=0, outclk held at 0, locked=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. The request is stored as pend_inc[ch] and sets pending[ch].
  - cfg_ready = !pending[cfg_ch] (combinational from registered state).
  - cfg_ch ≥ NUM_CH: accepted and ignored.
  - Pending increment applies on the cycle the channel's carry=1, or immediately if its current inc=0. It then clears pending and clears the lock counter and locked.
  - The accumulator is not cleared on apply, so phase is continuous.
- Sync, when sync=1:
  - All acc <= 0, clk_en <= 0, outclk <= 0, lock counters and locked cleared.
  - Any pending increment applies that same cycle.
  - All channels then restart in phase.
- Simultaneous events:
  - sync and cfg transfer in the same cycle: the new increment is stored as pending and applied at the next wrap. Sync does not consume it.
  - sync and carry in the same cycle: sync wins and no enable is emitted.
- Lock:
  - The counter increments on each clk_en and saturates at LOCK_CNT.
  - locked[i] = 1 while the counter equals LOCK_CNT. It is registered, so it rises one cycle after the LOCK_CNT-th clk_en.
- Channels are fully independent except for sync and the shared cfg port.

Test Plan:
- Reset with ACC_W=32 and defaults. Run 10,000 cycles, then count clk_en[0] pulses. Required: 5035 ±1 pulses, outclk toggling, locked=1 after the 16th enable.
- cfg ch1 inc=2^31 (ACC_W=32). Required: after apply, clk_en[1] pulses every 2nd cycle and locked[1] drops at apply and reasserts after 16 pulses. Channel 0 is unaffected.
- Issue a second cfg to ch1 while pending. Required: cfg_ready=0 until the apply cycle, then 1. A third cfg is accepted the following cycle.
- cfg inc=0, then inc=2^30. Required: clk_en stays low and locked=0 while off. The new inc applies on the cycle after acceptance and enables pulse every 4th cycle.
- Channels at 2^30 and 2^29, then pulse sync mid-run. Required: both accumulators are 0 the next cycle, ch0 pulses at sync+4 and ch1 at sync+8, and outclk and locked are cleared.
- Assert rst low for 1 cycle during a pending cfg. Required: all outputs zero, inc back to DEFAULT_INC, and the pending increment is never applied.
